// File: rtl/trng_pkg.sv
// Shared constants and the debias-phase type for the TRNG word collector.
package trng_pkg;
  localparam int TRNG_WORD_W    = 8;
  localparam int TRNG_DEPTH     = 4;
  localparam int TRNG_REP_LIMIT = 32;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;
endpackage

// File: rtl/trng_sync_fifo.sv
// First-word-fall-through word FIFO; head visible the cycle after the push edge.
// A push while full is taken only when a pop happens on the same edge, otherwise o_drop pulses.
module trng_sync_fifo #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WORD_W-1:0]              i_push_dat,
  input  logic                           i_pop,
  output logic [WORD_W-1:0]              o_dat,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_drop,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [WORD_W-1:0] r_hold;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_level = r_level;
  // When empty, keep presenting the last word that left so the output never goes stale-random.
  assign o_dat   = o_empty ? r_hold : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/trng_word_fifo.sv
// Samples raw TRNG bits, optionally von Neumann debiases, packs LSB-first into words and queues them;
// word visible one cycle after its last bit; full FIFO drops words (sticky overflow). TRNG_HEALTH_EN adds a repetition-count test.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WORD_W    = TRNG_WORD_W,
  parameter int DEPTH     = TRNG_DEPTH,
  parameter int DEBIAS    = 0,
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ro_en,
  input  logic                        start,
  input  logic                        raw_bit,
  output logic [WORD_W-1:0]           data,
  output logic                        data_vld,
  input  logic                        data_rdy,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  output logic                        overflow,
  output logic                        health_fail
);
  localparam int IW = $clog2(WORD_W);

  logic [IW-1:0]     r_idx;
  logic [WORD_W-2:0] r_word;
  phase_t            r_phase;
  logic              r_a;
  logic              r_overflow;
  logic              w_halt;
  logic              w_sample;
  logic              w_acc;
  logic              w_bit;
  logic              w_last;
  logic              w_push;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  logic [WORD_W-1:0] w_push_dat;

  assign w_sample = start & ro_en & ~w_halt;

  always_comb begin
    w_acc = 1'b0;
    w_bit = raw_bit;
    if (w_sample) begin
      if (DEBIAS == 0) begin
        w_acc = 1'b1;
      end else if (r_phase == PH_SECOND) begin
        w_acc = (r_a != raw_bit);
        w_bit = r_a;
      end
    end
  end

  assign w_last     = (r_idx == IW'(WORD_W-1));
  assign w_push     = w_acc & w_last;
  assign w_push_dat = {w_bit, r_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_word     <= '0;
      r_phase    <= PH_FIRST;
      r_a        <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_sample && DEBIAS != 0) begin
        if (r_phase == PH_FIRST) begin
          r_a     <= raw_bit;
          r_phase <= PH_SECOND;
        end else begin
          r_phase <= PH_FIRST;
        end
      end
      if (w_acc) begin
        for (int i = 0; i < WORD_W-1; i++) begin
          if (r_idx == IW'(i)) r_word[i] <= w_bit;
        end
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
  assign data_vld = ~w_empty;

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT+1);
  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run_nxt;
  logic          r_prev;
  logic          r_health;

  // A zero run count marks "no previous sample yet" after reset.
  assign w_run_nxt = ((r_run != '0) && (raw_bit == r_prev)) ? r_run + 1'b1 : RW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= '0;
      r_prev   <= 1'b0;
      r_health <= 1'b0;
    end else if (w_sample) begin
      r_prev <= raw_bit;
      r_run  <= w_run_nxt;
      if (w_run_nxt == RW'(REP_LIMIT)) r_health <= 1'b1;
    end
  end

  assign w_halt      = r_health;
  assign health_fail = r_health;
`else
  assign w_halt      = 1'b0;
  assign health_fail = 1'b0;
`endif

  trng_sync_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (data_rdy),
    .o_dat      (data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_drop     (w_drop),
    .o_level    (fifo_level)
  );

  // Fullness is already folded into o_drop; the flag itself is not needed here.
  logic w_full_unused;
  assign w_full_unused = w_full;
endmodule

// File: tb/tb_trng_word_fifo.sv
// Scoreboard bench: stimulus queues expected words, negedge monitors compare every popped word.
module tb_trng_word_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ro0, st0, raw0, rdy0, ovf0, hf0, vld0;
  logic [7:0] data0;
  logic [2:0] lvl0;
  logic       ro1, st1, raw1, rdy1, ovf1, hf1, vld1;
  logic [7:0] data1;
  logic [2:0] lvl1;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] e0, e1, w;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  trng_word_fifo #(.WORD_W(8), .DEPTH(4), .DEBIAS(0), .REP_LIMIT(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .ro_en(ro0), .start(st0), .raw_bit(raw0),
    .data(data0), .data_vld(vld0), .data_rdy(rdy0), .fifo_level(lvl0),
    .overflow(ovf0), .health_fail(hf0));

  trng_word_fifo #(.WORD_W(8), .DEPTH(4), .DEBIAS(1), .REP_LIMIT(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .ro_en(ro1), .start(st1), .raw_bit(raw1),
    .data(data1), .data_vld(vld1), .data_rdy(rdy1), .fifo_level(lvl1),
    .overflow(ovf1), .health_fail(hf1));

  // Monitors: a pop happens on the next posedge whenever vld & rdy are seen here.
  always @(negedge clk) begin
    if (rst_n && vld0 && rdy0) begin
      n_checks++;
      if (exp0.size() == 0) begin
        n_err++;
        $display("FAIL pop0: got %02h, no word expected", data0);
      end else begin
        e0 = exp0.pop_front();
        if (data0 !== e0) begin
          n_err++;
          $display("FAIL pop0: got %02h expected %02h", data0, e0);
        end
      end
    end
    if (rst_n && vld1 && rdy1) begin
      n_checks++;
      if (exp1.size() == 0) begin
        n_err++;
        $display("FAIL pop1: got %02h, no word expected", data1);
      end else begin
        e1 = exp1.pop_front();
        if (data1 !== e1) begin
          n_err++;
          $display("FAIL pop1: got %02h expected %02h", data1, e1);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit0(input logic b);
    raw0 = b; st0 = 1'b1; ro0 = 1'b1;
    step();
  endtask

  task automatic bit1(input logic b);
    raw1 = b; st1 = 1'b1; ro1 = 1'b1;
    step();
  endtask

  task automatic send0(input logic [7:0] v, input logic expect_it);
    if (expect_it) exp0.push_back(v);
    for (int i = 0; i < 8; i++) bit0(v[i]);
    st0 = 1'b0;
  endtask

  task automatic drain0(input int n);
    rdy0 = 1'b1;
    repeat (n) step();
    rdy0 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    ro0 = 0; st0 = 0; raw0 = 0; rdy0 = 0;
    ro1 = 0; st1 = 0; raw1 = 0; rdy1 = 0;
    repeat (2) step();
    chk("rst_data", data0, 8'h00);
    chk("rst_vld", vld0, 1'b0);
    chk("rst_level", lvl0, 3'd0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_health", hf0, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic packing and one-cycle latency: 1,0,1,1,0,0,0,1 -> 8'h8D
    w = 8'h8D;
    exp0.push_back(w);
    for (int i = 0; i < 7; i++) bit0(w[i]);
    chk("t1_vld_before", vld0, 1'b0);
    bit0(w[7]);
    st0 = 1'b0;
    chk("t1_vld", vld0, 1'b1);
    chk("t1_data", data0, 8'h8D);
    chk("t1_level", lvl0, 3'd1);
    drain0(1);
    chk("t1_level_after", lvl0, 3'd0);

    // Overflow: five words into a 4-deep FIFO, fifth dropped
    send0(8'hA1, 1); send0(8'hB2, 1); send0(8'hC3, 1); send0(8'hD4, 1);
    chk("t2_level4", lvl0, 3'd4);
    chk("t2_ovf_before", ovf0, 1'b0);
    send0(8'hE5, 0);
    chk("t2_level_full", lvl0, 3'd4);
    chk("t2_ovf", ovf0, 1'b1);
    drain0(4);
    chk("t2_level_empty", lvl0, 3'd0);
    chk("t2_vld_empty", vld0, 1'b0);
    chk("t2_data_hold", data0, 8'hD4);

    // Full FIFO with push and pop on the same edge
    do_reset();
    chk("t3_ovf_cleared", ovf0, 1'b0);
    send0(8'h11, 1); send0(8'h22, 1); send0(8'h33, 1); send0(8'h44, 1);
    w = 8'h55;
    for (int i = 0; i < 7; i++) bit0(w[i]);
    exp0.push_back(w);
    rdy0 = 1'b1;
    bit0(w[7]);
    rdy0 = 1'b0; st0 = 1'b0;
    chk("t3_level", lvl0, 3'd4);
    chk("t3_ovf", ovf0, 1'b0);
    drain0(4);
    chk("t3_level_empty", lvl0, 3'd0);

    // Pause mid-word via start and ro_en, then resume
    w = 8'h5A;
    exp0.push_back(w);
    for (int i = 0; i < 4; i++) bit0(w[i]);
    st0 = 1'b0;
    for (int i = 0; i < 3; i++) begin raw0 = ~raw0; step(); end
    st0 = 1'b1; ro0 = 1'b0; raw0 = 1'b1;
    step();
    chk("t4_level_paused", lvl0, 3'd0);
    for (int i = 4; i < 8; i++) bit0(w[i]);
    st0 = 1'b0;
    chk("t4_data", data0, 8'h5A);
    drain0(1);

    // Asynchronous reset mid-word with a stored word
    send0(8'hC6, 0);
    w = 8'hFF;
    for (int i = 0; i < 4; i++) bit0(w[i]);
    st0 = 1'b0;
    #2 rst_n = 1'b0;
    exp0.delete();
    #1;
    chk("t5_data", data0, 8'h00);
    chk("t5_vld", vld0, 1'b0);
    chk("t5_level", lvl0, 3'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send0(8'h3C, 1);
    chk("t5_new_word", data0, 8'h3C);
    drain0(1);

    // Debias: pairs 00,01,11,10 x4 -> bits 0,1,0,1,... -> 8'hAA
    rdy1 = 1'b1;
    exp1.push_back(8'hAA);
    for (int g = 0; g < 4; g++) begin
      bit1(0); bit1(0); bit1(0); bit1(1);
      bit1(1); bit1(1); bit1(1);
      if (g == 3) chk("t6_vld_before", vld1, 1'b0);
      bit1(0);
    end
    st1 = 1'b0;
    chk("t6_vld", vld1, 1'b1);
    chk("t6_data", data1, 8'hAA);
    step();
    chk("t6_level_after", lvl1, 3'd0);
    chk("t6_data_hold", data1, 8'hAA);
    for (int i = 0; i < 16; i++) bit1(i[1]);
    st1 = 1'b0;
    chk("t6_equal_pairs_none", lvl1, 3'd0);
    rdy1 = 1'b0;

`ifdef TRNG_HEALTH_EN
    do_reset();
    for (int i = 0; i < 31; i++) bit0(1'b1);
    chk("t7_health_before", hf0, 1'b0);
    bit0(1'b1);
    chk("t7_health", hf0, 1'b1);
    chk("t7_level", lvl0, 3'd4);
    for (int i = 0; i < 8; i++) bit0(1'b1);
    st0 = 1'b0;
    chk("t7_level_frozen", lvl0, 3'd4);
    chk("t7_ovf", ovf0, 1'b0);
    do_reset();
    chk("t7_health_reset", hf0, 1'b0);
`endif

    repeat (2) step();
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
